// File: rtl/bin_to_bcd_seq_pkg.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq_pkg
//   Shared definitions for the sequential binary-to-BCD converter:
//   FSM state encodings and the double-dabble nibble-adjust constants.
//   No ports (package).
// ---------------------------------------------------------------------------
package bin_to_bcd_seq_pkg;

  // FSM state encoding. The unused code 2'd3 is treated as IDLE by the top.
  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Double-dabble nibble adjust: any digit >= 5 gets +3 before the shift,
  // so that the shift's doubling carries correctly into the next digit.
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Adjust a single BCD nibble; the result never exceeds 4'd12 for a legal
  // digit input, so no carry out of the nibble is ever needed.
  function automatic logic [3:0] bcd_adjust(input logic [3:0] digit);
    bcd_adjust = (digit >= BCD_ADJ_THRESH) ? (digit + BCD_ADJ_ADD) : digit;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
//   Combinational nibble adjust used by the double-dabble datapath:
//   adjusted = (nibble >= 5) ? nibble + 3 : nibble. Never carries out.
// Ports
//   nibble    in   4  BCD digit of the scratch register before the shift
//   adjusted  out  4  digit after the add-3 correction
// ---------------------------------------------------------------------------
module bcd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = bcd_adjust(nibble);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   A START accepted in IDLE loads the operand into the low bits of a scratch
//   register; WIDTH edges later the packed BCD result is registered on BCD
//   and DONE pulses for one cycle. BCD holds until the next conversion ends.
// Ports
//   CLK    in   1          clock, rising edge
//   RST    in   1          synchronous active-high reset
//   START  in   1          conversion request, sampled only in IDLE
//   BIN    in   WIDTH      unsigned operand, captured when START is accepted
//   BUSY   out  1          high while converting
//   DONE   out  1          one-cycle pulse, BCD just updated
//   BCD    out  4*DIGITS   packed BCD, BCD[3:0] = units digit
// ---------------------------------------------------------------------------
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [WIDTH-1:0]      BIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   BCD
);

  localparam int SW = WIDTH + 4 * DIGITS;   // scratch width
  localparam int CW = $clog2(WIDTH + 1);    // bit counter width

  state_t                 state_reg;
  logic [CW-1:0]          cnt_reg;
  logic [SW-1:0]          scratch_reg;
  logic [4*DIGITS-1:0]    bcd_reg;
  logic                   busy_reg;
  logic                   done_reg;

  logic [SW-1:0]          adj_next;
  logic [SW-1:0]          shifted_next;

  // Binary part of the scratch passes through untouched; only the BCD
  // digit field above it gets the per-nibble correction.
  assign adj_next[WIDTH-1:0] = scratch_reg[WIDTH-1:0];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_add3 u_add3 (
        .nibble   (scratch_reg[WIDTH + 4*gi +: 4]),
        .adjusted (adj_next[WIDTH + 4*gi +: 4])
      );
    end
  endgenerate

  // The top bit shifted out is always zero given 10**DIGITS > 2**WIDTH-1.
  assign shifted_next = adj_next << 1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      scratch_reg <= '0;
      bcd_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (START) begin
            scratch_reg <= {{(4*DIGITS){1'b0}}, BIN};
            cnt_reg     <= CW'(WIDTH);
            busy_reg    <= 1'b1;
            state_reg   <= ST_CONV;
          end
        end

        ST_CONV: begin
          scratch_reg <= shifted_next;
          cnt_reg     <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            // Last bit: publish the digit field of the final shifted value.
            bcd_reg   <= shifted_next[SW-1 -: 4*DIGITS];
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: begin
          // Illegal encoding: fall back to a quiet IDLE.
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY = busy_reg;
  assign DONE = done_reg;
  assign BCD  = bcd_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [7:0]  BIN = 8'd0;
  logic        BUSY;
  logic        DONE;
  logic [11:0] BCD;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .BIN   (BIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .BCD   (BCD)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Waits for the converter to be idle, requests a conversion of b and
  // follows it to DONE. lat = samples after acceptance until DONE seen,
  // busy_cnt = samples with BUSY high. Sampling is 1 time unit after posedge.
  task automatic run_conv(input logic [7:0] b, output int lat, output int busy_cnt);
    int guard;
    guard = 0;
    @(negedge CLK);
    while ((BUSY || DONE) && guard < 30) begin
      @(negedge CLK);
      guard++;
    end
    START = 1'b1;
    BIN   = b;
    @(posedge CLK); #1;
    START = 1'b0;
    lat = 0;
    busy_cnt = BUSY ? 1 : 0;
    while (!DONE && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
      if (BUSY) busy_cnt++;
    end
  endtask

  initial begin
    int lat, bc, dcnt, bad_digit;
    logic [11:0] hold_bcd;

    // Reset for two cycles.
    repeat (2) @(posedge CLK);
    #1;
    check_eq("reset_bcd", 32'(BCD), 32'h000);
    check_eq("reset_busy", 32'(BUSY), 32'd0);
    check_eq("reset_done", 32'(DONE), 32'd0);
    RST = 1'b0;

    // 1. Zero: latency 8, BUSY high 8 samples, one-cycle DONE.
    run_conv(8'd0, lat, bc);
    check_eq("zero_latency", 32'(lat), 32'd8);
    check_eq("zero_bcd", 32'(BCD), 32'h000);
    check_eq("zero_busy_cycles", 32'(bc), 32'd8);
    @(posedge CLK); #1;
    check_eq("zero_done_pulse_width", 32'(DONE), 32'd0);

    // 2. Directed values.
    run_conv(8'd255, lat, bc);
    check_eq("max_bcd", 32'(BCD), 32'h255);
    check_eq("max_latency", 32'(lat), 32'd8);
    run_conv(8'd99, lat, bc);
    check_eq("bin99_bcd", 32'(BCD), 32'h099);
    run_conv(8'd100, lat, bc);
    check_eq("bin100_bcd", 32'(BCD), 32'h100);

    // 3. Exhaustive sweep against divide/mod model.
    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), lat, bc);
      if (lat != 8) check_eq($sformatf("sweep_latency_%0d", v), 32'(lat), 32'd8);
      check_eq($sformatf("sweep_bcd_%0d", v), 32'(BCD), 32'(ref_bcd(v)));
      bad_digit = ((BCD[3:0] > 4'd9) || (BCD[7:4] > 4'd9) || (BCD[11:8] > 4'd9)) ? 1 : 0;
      if (bad_digit != 0) check_eq($sformatf("sweep_digit_range_%0d", v), 32'(bad_digit), 32'd0);
    end

    // 4. START while busy is ignored.
    @(negedge CLK);
    while (BUSY || DONE) @(negedge CLK);
    START = 1'b1;
    BIN   = 8'd42;
    @(posedge CLK); #1;
    START = 1'b0;
    dcnt = 0;
    for (int c = 1; c <= 20; c++) begin
      START = (c == 3 || c == 8);
      BIN   = (c >= 3) ? 8'd7 : 8'd42;
      @(posedge CLK); #1;
      START = 1'b0;
      if (DONE) dcnt++;
    end
    check_eq("busy_start_done_count", 32'(dcnt), 32'd1);
    check_eq("busy_start_bcd", 32'(BCD), 32'h042);

    // 5. Reset mid-operation.
    run_conv(8'd200, lat, bc);
    check_eq("pre_reset_bcd", 32'(BCD), 32'h200);
    @(negedge CLK);
    while (BUSY || DONE) @(negedge CLK);
    START = 1'b1;
    BIN   = 8'd37;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_eq("midreset_bcd", 32'(BCD), 32'h000);
    check_eq("midreset_busy", 32'(BUSY), 32'd0);
    dcnt = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (DONE) dcnt++;
    end
    check_eq("midreset_no_done", 32'(dcnt), 32'd0);
    check_eq("midreset_bcd_after_wait", 32'(BCD), 32'h000);
    run_conv(8'd37, lat, bc);
    check_eq("after_reset_bcd", 32'(BCD), 32'h037);

    // 6. Hold while BIN toggles with START low.
    run_conv(8'd128, lat, bc);
    check_eq("hold_initial_bcd", 32'(BCD), 32'h128);
    @(posedge CLK); #1;
    hold_bcd = 12'h128;
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      BIN = 8'($urandom_range(0, 255));
      @(posedge CLK); #1;
      if (DONE) dcnt++;
      if (BCD !== hold_bcd) check_eq($sformatf("hold_bcd_cycle_%0d", c), 32'(BCD), 32'(hold_bcd));
    end
    check_eq("hold_bcd_final", 32'(BCD), 32'h128);
    check_eq("hold_no_done", 32'(dcnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
